// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: arctangent table, phase
// constants, controller state encoding and gain-compensation shift list.
package cordic_pkg;

  localparam logic [31:0] PHASE_90  = 32'h4000_0000;
  localparam logic [31:0] PHASE_180 = 32'h8000_0000;

  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9
  localparam int K_SHIFT_A = 1;
  localparam int K_SHIFT_B = 3;
  localparam int K_SHIFT_C = 6;
  localparam int K_SHIFT_D = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_GAIN = 3'd3,
    ST_DONE = 3'd4
  } cordic_state_e;

  // atan(2^-i) scaled so that 2^32 = 360 degrees
  function automatic logic [31:0] atan_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_entry = 32'h2000_0000;
      5'd1:    atan_entry = 32'h12E4_051E;
      5'd2:    atan_entry = 32'h09FB_385B;
      5'd3:    atan_entry = 32'h0511_11D4;
      5'd4:    atan_entry = 32'h028B_0D43;
      5'd5:    atan_entry = 32'h0145_D7E1;
      5'd6:    atan_entry = 32'h00A2_F61E;
      5'd7:    atan_entry = 32'h0051_7C55;
      5'd8:    atan_entry = 32'h0028_BE53;
      5'd9:    atan_entry = 32'h0014_5F2F;
      5'd10:   atan_entry = 32'h000A_2F98;
      5'd11:   atan_entry = 32'h0005_17CC;
      5'd12:   atan_entry = 32'h0002_8BE6;
      5'd13:   atan_entry = 32'h0001_45F3;
      5'd14:   atan_entry = 32'h0000_A2FA;
      5'd15:   atan_entry = 32'h0000_517D;
      5'd16:   atan_entry = 32'h0000_28BE;
      5'd17:   atan_entry = 32'h0000_145F;
      5'd18:   atan_entry = 32'h0000_0A30;
      5'd19:   atan_entry = 32'h0000_0518;
      5'd20:   atan_entry = 32'h0000_028C;
      5'd21:   atan_entry = 32'h0000_0146;
      5'd22:   atan_entry = 32'h0000_00A3;
      5'd23:   atan_entry = 32'h0000_0051;
      5'd24:   atan_entry = 32'h0000_0029;
      5'd25:   atan_entry = 32'h0000_0014;
      5'd26:   atan_entry = 32'h0000_000A;
      5'd27:   atan_entry = 32'h0000_0005;
      5'd28:   atan_entry = 32'h0000_0003;
      5'd29:   atan_entry = 32'h0000_0001;
      5'd30:   atan_entry = 32'h0000_0001;
      default: atan_entry = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_iter_rot.sv
// One combinational CORDIC micro-rotation with a runtime shift amount;
// direction is taken from the sign of the residual phase.
module cordic_iter_rot
  import cordic_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] x_cur,
  input  logic [W-1:0] y_cur,
  input  logic [31:0]  phase_cur,
  input  logic [4:0]   shift,
  output logic [W-1:0] x_nxt,
  output logic [W-1:0] y_nxt,
  output logic [31:0]  phase_nxt
);

  logic [W-1:0] x_sh_s;
  logic [W-1:0] y_sh_s;
  logic [31:0]  atan_s;

  // Shift-add rotation; both updates use the pre-rotation x and y
  always_comb begin
    x_sh_s = $signed(x_cur) >>> shift;
    y_sh_s = $signed(y_cur) >>> shift;
    atan_s = atan_entry(shift);
    if (phase_cur[31] == 1'b0) begin
      x_nxt     = x_cur - y_sh_s;
      y_nxt     = y_cur + x_sh_s;
      phase_nxt = phase_cur - atan_s;
    end else begin
      x_nxt     = x_cur + y_sh_s;
      y_nxt     = y_cur - x_sh_s;
      phase_nxt = phase_cur + atan_s;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine: FSM reuses one micro-rotation stage ITERS times.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation cycle before saturation.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int PHASE_W = 32,
  parameter int ITERS   = 16,
  parameter int GUARD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  x_in,
  input  logic [DATA_W-1:0]  y_in,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  x_out,
  output logic [DATA_W-1:0]  y_out,
  output logic [PHASE_W-1:0] phase_res,
  output logic               busy
);

  localparam int W = DATA_W + GUARD;

  cordic_state_e      state_r;
  cordic_state_e      state_nxt_s;
  logic [4:0]         cnt_r;
  logic [W-1:0]       x_r;
  logic [W-1:0]       y_r;
  logic [PHASE_W-1:0] phase_r;
  logic [W-1:0]       x_rot_s;
  logic [W-1:0]       y_rot_s;
  logic [PHASE_W-1:0] phase_rot_s;
  logic [DATA_W-1:0]  x_out_r;
  logic [DATA_W-1:0]  y_out_r;
  logic [PHASE_W-1:0] phase_res_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               last_iter_s;

  function automatic logic [DATA_W-1:0] sat_data(input logic [W-1:0] v);
    logic [W-DATA_W:0] top_bits;
    top_bits = v[W-1:DATA_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      sat_data = v[DATA_W-1:0];
    end else if (v[W-1]) begin
      sat_data = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_data = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic [W-1:0] gain_scale(input logic [W-1:0] v);
    logic [W-1:0] a, b, c, d;
    a = $signed(v) >>> K_SHIFT_A;
    b = $signed(v) >>> K_SHIFT_B;
    c = $signed(v) >>> K_SHIFT_C;
    d = $signed(v) >>> K_SHIFT_D;
    gain_scale = a + b - c - d;
  endfunction
`endif

  cordic_iter_rot #(.W(W)) u_rot (
    .x_cur     (x_r),
    .y_cur     (y_r),
    .phase_cur (phase_r),
    .shift     (cnt_r),
    .x_nxt     (x_rot_s),
    .y_nxt     (y_rot_s),
    .phase_nxt (phase_rot_s)
  );

  assign last_iter_s = (cnt_r == 5'(ITERS - 1));

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_LOAD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_ITER;
      ST_ITER: begin
        if (last_iter_s) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt_s = ST_GAIN;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: state_nxt_s = ST_DONE;
`endif
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, handshake flags, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      x_r         <= '0;
      y_r         <= '0;
      phase_r     <= '0;
      x_out_r     <= '0;
      y_out_r     <= '0;
      phase_res_r <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == ST_DONE);
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r     <= {{GUARD{x_in[DATA_W-1]}}, x_in};
            y_r     <= {{GUARD{y_in[DATA_W-1]}}, y_in};
            phase_r <= phase_in;
          end
          cnt_r <= 5'd0;
        end
        ST_LOAD: begin
          // Fold |angle| >= 90 deg into the convergence range by a half-turn
          if (phase_r[PHASE_W-1] ^ phase_r[PHASE_W-2]) begin
            x_r     <= -x_r;
            y_r     <= -y_r;
            phase_r <= phase_r + PHASE_180;
          end
          cnt_r <= 5'd0;
        end
        ST_ITER: begin
          x_r     <= x_rot_s;
          y_r     <= y_rot_s;
          phase_r <= phase_rot_s;
          cnt_r   <= cnt_r + 5'd1;
`ifndef CORDIC_GAIN_COMP_EN
          if (last_iter_s) begin
            x_out_r     <= sat_data(x_rot_s);
            y_out_r     <= sat_data(y_rot_s);
            phase_res_r <= phase_rot_s;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          x_out_r     <= sat_data(gain_scale(x_r));
          y_out_r     <= sat_data(gain_scale(y_r));
          phase_res_r <= phase_r;
        end
`endif
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign y_out     = y_out_r;
  assign phase_res = phase_res_r;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed-vector bench for cordic_iter_ctrl; expectations switch with CORDIC_GAIN_COMP_EN.
module tb_cordic_iter_ctrl;

  localparam int ITERS = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT_EXP = ITERS + 3;
`else
  localparam int LAT_EXP = ITERS + 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  x_in = 9'd0;
  logic [8:0]  y_in = 9'd0;
  logic [31:0] phase_in = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  x_out;
  logic [8:0]  y_out;
  logic [31:0] phase_res;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  cordic_iter_ctrl #(.DATA_W(9), .PHASE_W(32), .ITERS(ITERS), .GUARD(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .phase_in  (phase_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .phase_res (phase_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [31:0] ph;
    int          ex;
    int          ey;
    int          tx;
    int          ty;
  } vec_t;

  vec_t vecs [6];

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Present one job, return latency (edges from accept, inclusive) and results in first DONE cycle
  task automatic run_job(input logic [8:0] xi, input logic [8:0] yi, input logic [31:0] ph,
                         output int lat, output int xo, output int yo, output int res);
    @(negedge clk);
    x_in = xi; y_in = yi; phase_in = ph; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    xo  = $signed(x_out);
    yo  = $signed(y_out);
    res = $signed(phase_res);
  endtask

  int lat, xo, yo, res;
  int hx, hy, hres;

  initial begin
    // Expected values allow for the floor bias of arithmetic right shifts on 11-bit data
`ifdef CORDIC_GAIN_COMP_EN
    vecs[0] = '{9'd100,  9'd0, 32'h2000_0000,   71,   71, 3, 3};
    vecs[1] = '{9'd100,  9'd0, 32'h8000_0000, -100,    0, 3, 3};
    vecs[2] = '{9'h0FF,  9'd0, 32'h0000_0000,  255,    0, 0, 3};
    vecs[3] = '{9'h100,  9'd0, 32'h8000_0000,  255,    0, 0, 3};
    vecs[4] = '{9'h100,  9'd0, 32'h0000_0000, -256,    0, 0, 3};
    vecs[5] = '{9'd0,    9'd0, 32'h4000_0000,    0,    0, 0, 0};
`else
    vecs[0] = '{9'd100,  9'd0, 32'h2000_0000,  116,  116, 3, 3};
    vecs[1] = '{9'd100,  9'd0, 32'h8000_0000, -165,    0, 3, 3};
    vecs[2] = '{9'h0FF,  9'd0, 32'h0000_0000,  255,    0, 0, 3};
    vecs[3] = '{9'h100,  9'd0, 32'h8000_0000,  255,    0, 0, 3};
    vecs[4] = '{9'h100,  9'd0, 32'h0000_0000, -256,    0, 0, 3};
    vecs[5] = '{9'd0,    9'd0, 32'h4000_0000,    0,    0, 0, 0};
`endif

    // Reset, with out_ready high while nothing is valid
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_x_out", int'(x_out), 0);
    check_eq("rst_y_out", int'(y_out), 0);
    check_eq("rst_phase_res", int'(phase_res), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_out_valid", int'(out_valid), 0);

    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("row%0d_in_ready", i), int'(in_ready), 1);
      run_job(vecs[i].x, vecs[i].y, vecs[i].ph, lat, xo, yo, res);
      check_eq($sformatf("row%0d_latency", i), lat, LAT_EXP);
      check_near($sformatf("row%0d_x", i), xo, vecs[i].ex, vecs[i].tx);
      check_near($sformatf("row%0d_y", i), yo, vecs[i].ey, vecs[i].ty);
      check_near($sformatf("row%0d_phase_res", i), res, 0, 131071);
      @(posedge clk); #1;
      check_eq($sformatf("row%0d_released", i), int'(out_valid), 0);
    end

    // Back-pressure: result held for 5 cycles, in_valid during DONE ignored
    out_ready = 1'b0;
    run_job(vecs[0].x, vecs[0].y, vecs[0].ph, lat, hx, hy, hres);
    check_eq("bp_latency", lat, LAT_EXP);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; x_in = 9'd7; y_in = 9'd3; phase_in = 32'h1000_0000;
      @(posedge clk); #1;
      check_eq($sformatf("bp%0d_out_valid", c), int'(out_valid), 1);
      check_eq($sformatf("bp%0d_x_out", c), $signed(x_out), hx);
      check_eq($sformatf("bp%0d_y_out", c), $signed(y_out), hy);
      check_eq($sformatf("bp%0d_phase_res", c), $signed(phase_res), hres);
      check_eq($sformatf("bp%0d_in_ready", c), int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_done_out_valid", int'(out_valid), 0);
    check_eq("bp_done_in_ready", int'(in_ready), 1);
    check_eq("bp_done_busy", int'(busy), 0);
    @(posedge clk); #1;
    check_eq("bp_no_accept_busy", int'(busy), 0);

    // Reset in the middle of the iteration phase
    @(negedge clk);
    x_in = vecs[0].x; y_in = vecs[0].y; phase_in = vecs[0].ph; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_in_ready", int'(in_ready), 1);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_x_out", int'(x_out), 0);
    repeat (ITERS + 4) @(posedge clk);
    #1;
    check_eq("midrst_no_output", int'(out_valid), 0);
    run_job(vecs[0].x, vecs[0].y, vecs[0].ph, lat, xo, yo, res);
    check_eq("post_rst_latency", lat, LAT_EXP);
    check_near("post_rst_x", xo, vecs[0].ex, vecs[0].tx);
    check_near("post_rst_y", yo, vecs[0].ey, vecs[0].ty);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
